// File: rtl/regfile_access_ctrl_pkg.sv
// Shared encodings for the register-file access controller and its scoreboard.
package rf_access_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_READ = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = S_IDLE,
    ST_READ = S_READ,
    ST_HOLD = S_HOLD
  } state_e;

  // Architectural zero register index.
  localparam int unsigned X0 = 0;

endpackage

// File: rtl/regfile_access_ctrl_scoreboard.sv
// Pending-write scoreboard: one busy bit per architectural register.
// A set and a clear of the same bit on one edge leaves it set.
module rf_scoreboard
  import rf_access_pkg::*;
#(
  parameter int REG_DEPTH   = 32,
  parameter int RADDR_WIDTH = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   set_en,
  input  logic [RADDR_WIDTH-1:0] set_idx,
  input  logic                   clr_en,
  input  logic [RADDR_WIDTH-1:0] clr_idx,
  output logic [REG_DEPTH-1:0]   busy,
  output logic                   err
);

  localparam logic [RADDR_WIDTH-1:0] X0_ADDR = RADDR_WIDTH'(X0);

  logic [REG_DEPTH-1:0] busy_q, busy_d;
  logic                 err_q, err_d;

  always_comb begin
    busy_d = busy_q;
    err_d  = 1'b0;
    if (clr_en && (clr_idx != X0_ADDR)) begin
      // A writeback nobody was waiting for is flagged but still applied.
      err_d            = !busy_q[clr_idx];
      busy_d[clr_idx]  = 1'b0;
    end
    if (set_en && (set_idx != X0_ADDR)) begin
      busy_d[set_idx] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
      err_q  <= 1'b0;
    end else begin
      busy_q <= busy_d;
      err_q  <= err_d;
    end
  end

  assign busy = busy_q;
  assign err  = err_q;

endmodule

// File: rtl/regfile_access_ctrl.sv
// Register-file access controller: issue capture, RAW/WAW stall against the
// scoreboard, operand fetch with same-cycle writeback bypass, writeback forwarding.
module regfile_access_ctrl
  import rf_access_pkg::*;
#(
  parameter int REG_DEPTH   = 32,
  parameter int REG_WIDTH   = 32,
  parameter int RADDR_WIDTH = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   iss_valid,
  output logic                   iss_ready,
  input  logic [RADDR_WIDTH-1:0] iss_rs1,
  input  logic [RADDR_WIDTH-1:0] iss_rs2,
  input  logic [RADDR_WIDTH-1:0] iss_rd,
  input  logic                   iss_rd_we,
  output logic                   op_valid,
  input  logic                   op_ready,
  output logic [REG_WIDTH-1:0]   op_rs1_val,
  output logic [REG_WIDTH-1:0]   op_rs2_val,
  output logic [RADDR_WIDTH-1:0] op_rd,
  output logic                   op_rd_we,
  input  logic                   wb_valid,
  input  logic [RADDR_WIDTH-1:0] wb_rd,
  input  logic [REG_WIDTH-1:0]   wb_value,
  output logic [RADDR_WIDTH-1:0] rf_rs1_addr,
  output logic [RADDR_WIDTH-1:0] rf_rs2_addr,
  input  logic [REG_WIDTH-1:0]   rf_rs1_value,
  input  logic [REG_WIDTH-1:0]   rf_rs2_value,
  output logic                   rf_we,
  output logic [RADDR_WIDTH-1:0] rf_rd_addr,
  output logic [REG_WIDTH-1:0]   rf_rd_value,
  output logic [REG_DEPTH-1:0]   busy_regs,
  output logic                   wb_err
);

  localparam logic [RADDR_WIDTH-1:0] X0_ADDR = RADDR_WIDTH'(X0);

  state_e                 state_q, state_d;
  logic [RADDR_WIDTH-1:0] rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
  logic                   rd_we_q, rd_we_d;
  logic [REG_WIDTH-1:0]   op1_q, op1_d, op2_q, op2_d;

  logic hit_rs1, hit_rs2, hit_rd;
  logic stall, fire, sb_set_en;

  function automatic logic wb_hits(input logic                   vld,
                                   input logic [RADDR_WIDTH-1:0] wb_idx,
                                   input logic [RADDR_WIDTH-1:0] idx);
    return vld && (wb_idx == idx) && (idx != X0_ADDR);
  endfunction

  // x0 reads as zero; a matching writeback beats the stale register-file value.
  function automatic logic [REG_WIDTH-1:0] pick_operand(input logic [RADDR_WIDTH-1:0] idx,
                                                        input logic                   hit,
                                                        input logic [REG_WIDTH-1:0]   wb_val,
                                                        input logic [REG_WIDTH-1:0]   rf_val);
    if (idx == X0_ADDR) return '0;
    if (hit)            return wb_val;
    return rf_val;
  endfunction

  assign hit_rs1 = wb_hits(wb_valid, wb_rd, rs1_q);
  assign hit_rs2 = wb_hits(wb_valid, wb_rd, rs2_q);
  assign hit_rd  = wb_hits(wb_valid, wb_rd, rd_q);

  assign stall = (busy_regs[rs1_q] && !hit_rs1) ||
                 (busy_regs[rs2_q] && !hit_rs2) ||
                 (rd_we_q && busy_regs[rd_q] && !hit_rd);

  assign fire      = (state_q == ST_READ) && !stall;
  assign sb_set_en = fire && rd_we_q && (rd_q != X0_ADDR);

  always_comb begin
    state_d = state_q;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    rd_d    = rd_q;
    rd_we_d = rd_we_q;
    op1_d   = op1_q;
    op2_d   = op2_q;
    case (state_q)
      ST_IDLE: begin
        if (iss_valid) begin
          rs1_d   = iss_rs1;
          rs2_d   = iss_rs2;
          rd_d    = iss_rd;
          rd_we_d = iss_rd_we;
          state_d = ST_READ;
        end
      end
      ST_READ: begin
        if (!stall) begin
          op1_d   = pick_operand(rs1_q, hit_rs1, wb_value, rf_rs1_value);
          op2_d   = pick_operand(rs2_q, hit_rs2, wb_value, rf_rs2_value);
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (op_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      rs1_q   <= '0;
      rs2_q   <= '0;
      rd_q    <= '0;
      rd_we_q <= 1'b0;
      op1_q   <= '0;
      op2_q   <= '0;
    end else begin
      state_q <= state_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      rd_q    <= rd_d;
      rd_we_q <= rd_we_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
    end
  end

  rf_scoreboard #(
    .REG_DEPTH  (REG_DEPTH),
    .RADDR_WIDTH(RADDR_WIDTH)
  ) u_scoreboard (
    .clk    (clk),
    .rst    (rst),
    .set_en (sb_set_en),
    .set_idx(rd_q),
    .clr_en (wb_valid),
    .clr_idx(wb_rd),
    .busy   (busy_regs),
    .err    (wb_err)
  );

  assign iss_ready   = (state_q == ST_IDLE);
  assign op_valid    = (state_q == ST_HOLD);
  assign op_rs1_val  = op1_q;
  assign op_rs2_val  = op2_q;
  // Captured request is frozen from READ through HOLD, so it doubles as the passthrough.
  assign op_rd       = rd_q;
  assign op_rd_we    = rd_we_q;
  assign rf_rs1_addr = rs1_q;
  assign rf_rs2_addr = rs2_q;

  assign rf_we       = wb_valid && (wb_rd != X0_ADDR);
  assign rf_rd_addr  = wb_rd;
  assign rf_rd_value = wb_value;

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Self-checking bench for regfile_access_ctrl with a behavioural register file.
module tb_regfile_access_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        iss_valid, iss_ready;
  logic [4:0]  iss_rs1, iss_rs2, iss_rd;
  logic        iss_rd_we;
  logic        op_valid, op_ready;
  logic [31:0] op_rs1_val, op_rs2_val;
  logic [4:0]  op_rd;
  logic        op_rd_we;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_value;
  logic [4:0]  rf_rs1_addr, rf_rs2_addr;
  logic [31:0] rf_rs1_value, rf_rs2_value;
  logic        rf_we;
  logic [4:0]  rf_rd_addr;
  logic [31:0] rf_rd_value;
  logic [31:0] busy_regs;
  logic        wb_err;

  int checks = 0;
  int errors = 0;

  logic [31:0] rf_mem [32];

  typedef struct {
    logic [31:0] v1, v2, busy;
    logic [4:0]  rd;
    logic        we;
  } exp_t;
  exp_t exp_q[$];

  typedef struct {
    logic [4:0]  rs1, rs2, rd;
    logic        we;
    logic [31:0] e1, e2, wbv;
  } vec_t;
  vec_t tbl[6];

  regfile_access_ctrl dut (
    .clk(clk), .rst(rst),
    .iss_valid(iss_valid), .iss_ready(iss_ready),
    .iss_rs1(iss_rs1), .iss_rs2(iss_rs2), .iss_rd(iss_rd), .iss_rd_we(iss_rd_we),
    .op_valid(op_valid), .op_ready(op_ready),
    .op_rs1_val(op_rs1_val), .op_rs2_val(op_rs2_val), .op_rd(op_rd), .op_rd_we(op_rd_we),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_value(wb_value),
    .rf_rs1_addr(rf_rs1_addr), .rf_rs2_addr(rf_rs2_addr),
    .rf_rs1_value(rf_rs1_value), .rf_rs2_value(rf_rs2_value),
    .rf_we(rf_we), .rf_rd_addr(rf_rd_addr), .rf_rd_value(rf_rd_value),
    .busy_regs(busy_regs), .wb_err(wb_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (rf_we) rf_mem[rf_rd_addr] <= rf_rd_value;
  assign rf_rs1_value = rf_mem[rf_rs1_addr];
  assign rf_rs2_value = rf_mem[rf_rs2_addr];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the capture edge.
  task automatic issue(input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic we);
    int n = 0;
    while (!iss_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("iss_ready_before_issue", iss_ready, 1);
    iss_valid = 1'b1;
    iss_rs1   = rs1;
    iss_rs2   = rs2;
    iss_rd    = rd;
    iss_rd_we = we;
    @(negedge clk);
    iss_valid = 1'b0;
  endtask

  task automatic run_txn(input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic we,
                         input logic [31:0] e1, input logic [31:0] e2, input string tag);
    exp_t e;
    int   n = 0;
    op_ready = 1'b1;
    e.v1   = e1;
    e.v2   = e2;
    e.rd   = rd;
    e.we   = we;
    e.busy = (we && rd != 5'd0) ? (32'd1 << rd) : 32'd0;
    exp_q.push_back(e);
    issue(rs1, rs2, rd, we);
    while (!op_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_latency"}, 32'(n), 32'd1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({tag, "_rs1_val"}, op_rs1_val, e.v1);
      chk({tag, "_rs2_val"}, op_rs2_val, e.v2);
      chk({tag, "_rd"}, 32'(op_rd), 32'(e.rd));
      chk({tag, "_rd_we"}, 32'(op_rd_we), 32'(e.we));
      chk({tag, "_busy"}, busy_regs, e.busy);
    end
  endtask

  // Called at a negedge; returns two negedges later.
  task automatic wb(input logic [4:0] rd, input logic [31:0] val,
                    input logic exp_we, input logic exp_err);
    wb_valid = 1'b1;
    wb_rd    = rd;
    wb_value = val;
    #1;
    chk("rf_we", rf_we, exp_we);
    chk("rf_rd_addr", 32'(rf_rd_addr), 32'(rd));
    chk("rf_rd_value", rf_rd_value, val);
    @(negedge clk);
    wb_valid = 1'b0;
    chk("wb_err", wb_err, exp_err);
    @(negedge clk);
    chk("wb_err_one_cycle", wb_err, 0);
  endtask

  initial begin
    tbl[0] = '{5'd1,  5'd2,  5'd3,  1'b1, 32'd5,     32'd7,     32'h33};
    tbl[1] = '{5'd3,  5'd0,  5'd4,  1'b1, 32'h33,    32'd0,     32'h44};
    tbl[2] = '{5'd4,  5'd4,  5'd0,  1'b1, 32'h44,    32'h44,    32'd0};
    tbl[3] = '{5'd31, 5'd10, 5'd31, 1'b0, 32'h11F,   32'h10A,   32'd0};
    tbl[4] = '{5'd0,  5'd31, 5'd5,  1'b1, 32'd0,     32'h11F,   32'h55};
    tbl[5] = '{5'd5,  5'd3,  5'd6,  1'b0, 32'h55,    32'h33,    32'd0};

    rst = 1'b1;
    iss_valid = 1'b0; iss_rs1 = '0; iss_rs2 = '0; iss_rd = '0; iss_rd_we = 1'b0;
    op_ready = 1'b1;
    wb_valid = 1'b0; wb_rd = '0; wb_value = '0;

    @(negedge clk);
    chk("reset_op_valid", op_valid, 0);
    chk("reset_busy", busy_regs, 0);
    chk("reset_iss_ready", iss_ready, 1);
    chk("reset_op_rs1_val", op_rs1_val, 0);
    chk("reset_op_rd", 32'(op_rd), 0);
    chk("reset_wb_err", wb_err, 0);
    rst = 1'b0;
    @(negedge clk);

    // Preload through the writeback path; none are pending so each flags wb_err.
    wb(5'd1,  32'd5,    1'b1, 1'b1);
    wb(5'd2,  32'd7,    1'b1, 1'b1);
    wb(5'd10, 32'h10A,  1'b1, 1'b1);
    wb(5'd31, 32'h11F,  1'b1, 1'b1);

    for (int i = 0; i < 6; i++) begin
      run_txn(tbl[i].rs1, tbl[i].rs2, tbl[i].rd, tbl[i].we, tbl[i].e1, tbl[i].e2,
              $sformatf("vec%0d", i));
      if (tbl[i].we && tbl[i].rd != 5'd0) wb(tbl[i].rd, tbl[i].wbv, 1'b1, 1'b0);
    end

    // RAW stall on pending x3, released by a bypassed writeback, then HOLD back-pressure.
    run_txn(5'd1, 5'd2, 5'd3, 1'b1, 32'd5, 32'd7, "raw_setup");
    issue(5'd3, 5'd1, 5'd7, 1'b1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stall_op_valid", op_valid, 0);
      chk("stall_iss_ready", iss_ready, 0);
    end
    chk("stall_busy", busy_regs, 32'h8);
    op_ready = 1'b0;
    wb_valid = 1'b1; wb_rd = 5'd3; wb_value = 32'h1234;
    @(negedge clk);
    wb_valid = 1'b0;
    chk("bypass_op_valid", op_valid, 1);
    chk("bypass_rs1_val", op_rs1_val, 32'h1234);
    chk("bypass_rs2_val", op_rs2_val, 32'd5);
    chk("bypass_busy", busy_regs, 32'h80);
    chk("bypass_wb_err", wb_err, 0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("hold_op_valid", op_valid, 1);
      chk("hold_rs1_val", op_rs1_val, 32'h1234);
      chk("hold_rs2_val", op_rs2_val, 32'd5);
      chk("hold_rd", 32'(op_rd), 32'd7);
      chk("hold_rd_we", op_rd_we, 1);
      chk("hold_iss_ready", iss_ready, 0);
    end
    op_ready = 1'b1;
    @(negedge clk);
    chk("release_op_valid", op_valid, 0);
    chk("release_iss_ready", iss_ready, 1);
    wb(5'd7, 32'h77, 1'b1, 1'b0);

    // x0 destination and writeback never become pending nor reach the register file.
    run_txn(5'd0, 5'd0, 5'd0, 1'b1, 32'd0, 32'd0, "x0_dest");
    wb(5'd0, 32'hBEEF, 1'b0, 1'b0);
    chk("x0_busy", busy_regs, 0);

    // Unexpected writeback to a non-pending register.
    wb(5'd9, 32'hDEAD, 1'b1, 1'b1);

    // Asynchronous reset while stalled in READ on pending x3.
    run_txn(5'd1, 5'd2, 5'd3, 1'b1, 32'd5, 32'd7, "rst_setup");
    issue(5'd3, 5'd0, 5'd0, 1'b0);
    @(negedge clk);
    chk("pre_rst_op_valid", op_valid, 0);
    chk("pre_rst_busy", busy_regs, 32'h8);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_op_valid", op_valid, 0);
    chk("async_rst_busy", busy_regs, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_iss_ready", iss_ready, 1);
    @(negedge clk);
    run_txn(5'd3, 5'd2, 5'd0, 1'b0, 32'h1234, 32'd7, "post_rst");

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
